// File: rtl/aes_round_ctrl_if.sv
// Handshake and control bundle between the AES round sequencer and its
// surroundings (block input/output handshake, key schedule, round datapath).
interface aes_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       rk_valid;
  logic [3:0] rk_idx;
  logic       sb_en;
  logic       sr_en;
  logic       mc_en;
  logic       ark_en;
  logic       state_sel;
  logic [3:0] round;
  logic       busy;
  logic       out_valid;
  logic       out_ready;

  // Sequencer side: drives enables, selects and round index.
  modport master (
    input  in_valid, rk_valid, out_ready,
    output in_ready, rk_idx, sb_en, sr_en, mc_en, ark_en,
           state_sel, round, busy, out_valid
  );

  // Datapath / environment side.
  modport slave (
    output in_valid, rk_valid, out_ready,
    input  in_ready, rk_idx, sb_en, sr_en, mc_en, ark_en,
           state_sel, round, busy, out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer. Walks one block through the initial key add and
// NR rounds of SubBytes/ShiftRows/MixColumns/AddRoundKey, issuing a one-cycle
// start pulse per stage and holding each stage for its register latency.
// Key-add stages wait for the key schedule (rk_valid) before starting.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int SB_LAT  = 1,
  parameter int SR_LAT  = 2,
  parameter int MC_LAT  = 1,
  parameter int ARK_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  aes_round_ctrl_if.master bus
);

  localparam int MAX_A   = (SB_LAT > SR_LAT) ? SB_LAT : SR_LAT;
  localparam int MAX_B   = (MC_LAT > ARK_LAT) ? MC_LAT : ARK_LAT;
  localparam int MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [2:0] {
    IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE
  } state_t;

  state_t             state_q, state_d, nxt;
  logic [3:0]         round_q, round_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   lat_cur;
  logic               key_stage;
  logic               active;
  logic               start;

  // Occupancy of each stage state in cycles; zero for the non-stage states.
  function automatic logic [CNT_W-1:0] lat_of(input state_t s);
    case (s)
      INIT_ARK: lat_of = CNT_W'(ARK_LAT);
      SUB:      lat_of = CNT_W'(SB_LAT);
      SHIFT:    lat_of = CNT_W'(SR_LAT);
      MIX:      lat_of = CNT_W'(MC_LAT);
      ARK:      lat_of = CNT_W'(ARK_LAT);
      default:  lat_of = '0;
    endcase
  endfunction

  // State, round and latency counter registers; abandon any block on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. cnt_q is loaded with the stage latency on entry, so
  // cnt_q == latency means the stage has not started yet (key stalls freeze
  // it there); it then counts down and the stage exits when it reaches 1.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    cnt_d     = cnt_q;
    nxt       = state_q;
    start     = 1'b0;
    active    = 1'b0;
    lat_cur   = lat_of(state_q);
    key_stage = (state_q == INIT_ARK) || (state_q == ARK);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = INIT_ARK;
          round_d = '0;
          cnt_d   = lat_of(INIT_ARK);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: begin
        active = 1'b1;
        if (cnt_q == lat_cur) begin
          if (key_stage && !bus.rk_valid) begin
            active = 1'b0;
          end else begin
            start = 1'b1;
          end
        end
        if (active) begin
          if (cnt_q == CNT_W'(1)) begin
            case (state_q)
              INIT_ARK: begin
                nxt     = SUB;
                round_d = 4'd1;
              end
              SUB:   nxt = SHIFT;
              SHIFT: nxt = (round_q < NR_L) ? MIX : ARK;
              MIX:   nxt = ARK;
              default: begin
                if (round_q < NR_L) begin
                  nxt     = SUB;
                  round_d = round_q + 4'd1;
                end else begin
                  nxt = DONE;
                end
              end
            endcase
            state_d = nxt;
            cnt_d   = lat_of(nxt);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Outputs decoded from registered state; ark_en additionally gates on
  // rk_valid so a key arriving this cycle starts the key add this cycle.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.state_sel = (state_q != INIT_ARK);
  assign bus.round     = round_q;
  assign bus.rk_idx    = round_q;
  assign bus.sb_en     = start && (state_q == SUB);
  assign bus.sr_en     = start && (state_q == SHIFT);
  assign bus.mc_en     = start && (state_q == MIX);
  assign bus.ark_en    = start && key_stage;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a queue-of-operations reference model derived
// from the round schedule, directed latency/stall/backpressure/abort cases
// and a randomized phase.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam int SB_LAT = 1, SR_LAT = 2, MC_LAT = 1, ARK_LAT = 1;
  localparam int K_INIT = 0, K_SB = 1, K_SR = 2, K_MC = 3, K_ARK = 4;

  typedef struct {
    int kind;
    int lat;
    int rnd;
  } op_t;

  logic clk;
  logic reset;
  aes_round_ctrl_if bus ();

  aes_round_ctrl #(
    .NR(NR), .SB_LAT(SB_LAT), .SR_LAT(SR_LAT), .MC_LAT(MC_LAT), .ARK_LAT(ARK_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state
  op_t opq[$];
  int  phase = 0;      // 0 idle, 1 running, 2 done
  bit  started = 0;
  int  rem = 0;
  int  cyc = 0;
  int  acc_cyc = -1;
  int  ov_cyc = -1;
  int  ov_n = 0;
  int  n_sb = 0, n_sr = 0, n_mc = 0, n_ark = 0;
  int  last_sr_cyc = -100;
  int  ark10_sr_gap = -1;
  int  ark10_idx = -1;
  bit  mc_in_r10 = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of_kind(input int k);
    case (k)
      K_SB:    return SB_LAT;
      K_SR:    return SR_LAT;
      K_MC:    return MC_LAT;
      default: return ARK_LAT;
    endcase
  endfunction

  task automatic push_op(input int k, input int r);
    op_t o;
    o.kind = k;
    o.lat  = lat_of_kind(k);
    o.rnd  = r;
    opq.push_back(o);
  endtask

  // The full operation list for one block, straight from the round rules.
  task automatic build_block();
    opq.delete();
    push_op(K_INIT, 0);
    for (int r = 1; r <= NR; r++) begin
      push_op(K_SB, r);
      push_op(K_SR, r);
      if (r < NR) push_op(K_MC, r);
      push_op(K_ARK, r);
    end
  endtask

  task automatic model_reset();
    opq.delete();
    phase   = 0;
    started = 0;
    rem     = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model.
  task automatic step(input bit iv, input bit rv, input bit ordy);
    int e_en[4];
    int e_round, e_sel;
    op_t op;
    bus.in_valid  = iv;
    bus.rk_valid  = rv;
    bus.out_ready = ordy;
    #1;
    e_en    = '{0, 0, 0, 0};
    e_round = 0;
    e_sel   = 1;
    if (phase == 1) begin
      op      = opq[0];
      e_round = op.rnd;
      e_sel   = (op.kind == K_INIT) ? 0 : 1;
      if (!started && !((op.kind == K_INIT || op.kind == K_ARK) && !rv)) begin
        started = 1;
        rem     = op.lat;
        case (op.kind)
          K_SB:    e_en[0] = 1;
          K_SR:    e_en[1] = 1;
          K_MC:    e_en[2] = 1;
          default: e_en[3] = 1;
        endcase
      end
    end else if (phase == 2) begin
      e_round = NR;
    end
    chk("in_ready", int'(bus.in_ready), (phase == 0) ? 1 : 0);
    chk("out_valid", int'(bus.out_valid), (phase == 2) ? 1 : 0);
    chk("busy", int'(bus.busy), (phase == 1) ? 1 : 0);
    chk("round", int'(bus.round), e_round);
    chk("rk_idx", int'(bus.rk_idx), e_round);
    chk("state_sel", int'(bus.state_sel), e_sel);
    chk("sb_en", int'(bus.sb_en), e_en[0]);
    chk("sr_en", int'(bus.sr_en), e_en[1]);
    chk("mc_en", int'(bus.mc_en), e_en[2]);
    chk("ark_en", int'(bus.ark_en), e_en[3]);

    // observation bookkeeping for the block-level checks
    if (bus.sb_en) n_sb++;
    if (bus.mc_en) begin
      n_mc++;
      if (bus.round == 4'd10) mc_in_r10 = 1;
    end
    if (bus.sr_en) begin
      n_sr++;
      last_sr_cyc = cyc;
    end
    if (bus.ark_en) begin
      n_ark++;
      if (bus.round == 4'd10) begin
        ark10_sr_gap = cyc - last_sr_cyc;
        ark10_idx    = int'(bus.rk_idx);
      end
    end
    if (bus.out_valid) begin
      ov_n++;
      if (ov_cyc < 0) ov_cyc = cyc;
    end

    case (phase)
      0: if (iv) begin
        build_block();
        phase   = 1;
        started = 0;
        acc_cyc = cyc;
        ov_cyc  = -1;
        ov_n    = 0;
        n_sb = 0; n_sr = 0; n_mc = 0; n_ark = 0;
        mc_in_r10 = 0;
        ark10_sr_gap = -1;
        ark10_idx = -1;
      end
      1: if (started) begin
        rem--;
        if (rem == 0) begin
          void'(opq.pop_front());
          started = 0;
          if (opq.size() == 0) phase = 2;
        end
      end
      default: if (ordy) phase = 0;
    endcase
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Run until the model returns to idle, with a cycle budget.
  task automatic finish_block(input string tag);
    int n = 0;
    while (phase != 0 && n < 300) begin
      step(1'b0, 1'b1, 1'b1);
      n++;
    end
    chk({tag, "_timeout"}, (n < 300) ? 1 : 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_round"}, int'(bus.round), 0);
    chk({tag, "_rk_idx"}, int'(bus.rk_idx), 0);
    chk({tag, "_sel"}, int'(bus.state_sel), 1);
    chk({tag, "_ens"}, int'({bus.sb_en, bus.sr_en, bus.mc_en, bus.ark_en}), 0);
  endtask

  task automatic nominal_block(input string tag);
    step(1'b1, 1'b1, 1'b1);
    finish_block(tag);
    chk({tag, "_lat"}, ov_cyc - acc_cyc, 51);
    chk({tag, "_ov_cycles"}, ov_n, 1);
    chk({tag, "_n_ark"}, n_ark, 11);
    chk({tag, "_n_sb"}, n_sb, 10);
    chk({tag, "_n_sr"}, n_sr, 10);
    chk({tag, "_n_mc"}, n_mc, 9);
    chk({tag, "_r10_gap"}, ark10_sr_gap, 2);
    chk({tag, "_r10_idx"}, ark10_idx, 10);
    chk({tag, "_r10_nomc"}, int'(mc_in_r10), 0);
  endtask

  initial begin
    int n;
    int stall_n;
    bit iv, rv, ordy;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.rk_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    check_reset_vals("rst0");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1);

    // nominal block with default latencies
    nominal_block("nom");
    step(1'b0, 1'b1, 1'b1);

    // key stall: rk_valid low for 3 cycles at entry to round-5 key add
    step(1'b1, 1'b1, 1'b1);
    stall_n = 0;
    n = 0;
    while (phase != 0 && n < 300) begin
      rv = 1'b1;
      if (phase == 1 && opq[0].kind == K_ARK && opq[0].rnd == 5 && !started && stall_n < 3) begin
        rv = 1'b0;
        stall_n++;
        chk("stall_round", int'(bus.round), 5);
      end
      step(1'b0, rv, 1'b1);
      n++;
    end
    chk("stall_timeout", (n < 300) ? 1 : 0, 1);
    chk("stall_lat", ov_cyc - acc_cyc, 54);
    chk("stall_n_ark", n_ark, 11);

    // output backpressure with a competing in_valid during DONE
    step(1'b1, 1'b1, 1'b1);
    n = 0;
    while (phase != 2 && n < 300) begin
      step(1'b0, 1'b1, 1'b1);
      n++;
    end
    chk("bp_timeout", (n < 300) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", int'(bus.in_ready), 0);
      step(1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1);
    chk("bp_ov_cycles", ov_n, 5);
    chk("bp_idle_ready", int'(bus.in_ready), 1);
    step(1'b1, 1'b1, 1'b1);
    chk("bp_accept_busy", int'(bus.busy), 1);
    finish_block("bp2");

    // abort in round-6 MixColumns, then a clean block
    step(1'b1, 1'b1, 1'b1);
    n = 0;
    while (!(phase == 1 && opq[0].kind == K_MC && opq[0].rnd == 6) && n < 300) begin
      step(1'b0, 1'b1, 1'b1);
      n++;
    end
    chk("abort_reach", (n < 300) ? 1 : 0, 1);
    chk("abort_pre_mc", int'(bus.mc_en), 1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #2;
    check_reset_vals("abort");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    ov_n = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    chk("abort_no_ov", ov_n, 0);
    nominal_block("post");

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      iv   = ($urandom_range(0, 3) == 0);
      rv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) == 0);
      step(iv, rv, ordy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
